// File: rtl/cpu_lockstep_cmp_if.sv
// Commit-event bus between the two CPU models and the lockstep checker.
//   ref_valid/ref_data : per-channel commit strobes and data from the reference model
//   duv_valid/duv_data : per-channel commit strobes and data from the DUV
//   Channel c occupies data bits [c*DATA_W +: DATA_W].
//   master : the models driving commits; slave : the checker receiving them.
interface cpu_lockstep_cmp_if #(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned DATA_W = 8
);
  logic [NUM_CH-1:0]        ref_valid;
  logic [NUM_CH*DATA_W-1:0] ref_data;
  logic [NUM_CH-1:0]        duv_valid;
  logic [NUM_CH*DATA_W-1:0] duv_data;

  modport master (output ref_valid, ref_data, duv_valid, duv_data);
  modport slave  (input  ref_valid, ref_data, duv_valid, duv_data);
endinterface

// File: rtl/cpu_lockstep_cmp.sv
// Lockstep checker: buffers per-channel commit events from the reference and
// DUV models in per-side FIFOs, compares them in order, counts matches and
// errors, captures the first mismatch, flags FIFO overflow and skew timeout,
// and optionally halts on the first error.
//   clk, rst_n        : clock, async active-low reset
//   enable            : run checking (0 = idle, FIFO contents kept)
//   stop_on_err       : halt on first mismatch/timeout
//   clr               : synchronous clear of FIFOs, counters and flags
//   bus               : commit strobes/data from both models (slave modport)
//   state             : 0 IDLE, 1 RUN, 2 HALT
//   match_cnt/err_cnt : saturating compare counters
//   err_flag, first_err_ch/ref/duv : sticky first-mismatch capture
//   ovf_flag          : per channel, a push was dropped on a full FIFO
//   timeout_flag      : per channel, one side stayed ahead for MAX_SKEW cycles
module cpu_lockstep_cmp #(
  parameter int unsigned NUM_CH   = 3,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned MAX_SKEW = 16,
  parameter int unsigned CNT_W    = 16,
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 stop_on_err,
  input  logic                 clr,
  cpu_lockstep_cmp_if.slave    bus,
  output logic [1:0]           state,
  output logic [CNT_W-1:0]     match_cnt,
  output logic [CNT_W-1:0]     err_cnt,
  output logic                 err_flag,
  output logic [CH_W-1:0]      first_err_ch,
  output logic [DATA_W-1:0]    first_err_ref,
  output logic [DATA_W-1:0]    first_err_duv,
  output logic [NUM_CH-1:0]    ovf_flag,
  output logic [NUM_CH-1:0]    timeout_flag
);
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PW    = AW + 1;
  localparam int unsigned SK_W  = $clog2(MAX_SKEW + 1);
  localparam int unsigned PC_W  = $clog2(NUM_CH + 1);
  localparam int unsigned SUM_W = CNT_W + PC_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } st_e;

  st_e st;

  logic [DATA_W-1:0] ref_mem [NUM_CH][DEPTH];
  logic [DATA_W-1:0] duv_mem [NUM_CH][DEPTH];
  logic [PW-1:0]     ref_wp  [NUM_CH];
  logic [PW-1:0]     ref_rp  [NUM_CH];
  logic [PW-1:0]     duv_wp  [NUM_CH];
  logic [PW-1:0]     duv_rp  [NUM_CH];
  logic [SK_W-1:0]   skew    [NUM_CH];

  logic              run_c;
  logic [NUM_CH-1:0] ref_empty_c, ref_full_c, duv_empty_c, duv_full_c;
  logic [NUM_CH-1:0] pop_c, ref_push_c, duv_push_c, ovf_set_c;
  logic [NUM_CH-1:0] one_side_c, tmo_set_c, match_c, mis_c;
  logic [PC_W-1:0]   n_match_c, n_mis_c;
  logic [CH_W-1:0]   mis_ch_c;
  logic [DATA_W-1:0] mis_ref_c, mis_duv_c;
  logic [SUM_W-1:0]  match_sum_c, err_sum_c;
  logic [CNT_W-1:0]  match_nx_c, err_nx_c;

  assign state = st;

  // FIFO status, push/pop decisions, compare results and skew timeout events
  always_comb begin
    run_c       = (st == S_RUN);
    ref_empty_c = '0;
    ref_full_c  = '0;
    duv_empty_c = '0;
    duv_full_c  = '0;
    pop_c       = '0;
    ref_push_c  = '0;
    duv_push_c  = '0;
    ovf_set_c   = '0;
    one_side_c  = '0;
    tmo_set_c   = '0;
    match_c     = '0;
    mis_c       = '0;
    n_match_c   = '0;
    n_mis_c     = '0;
    mis_ch_c    = '0;
    mis_ref_c   = '0;
    mis_duv_c   = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      ref_empty_c[c] = (ref_wp[c] == ref_rp[c]);
      duv_empty_c[c] = (duv_wp[c] == duv_rp[c]);
      ref_full_c[c]  = (ref_wp[c][AW-1:0] == ref_rp[c][AW-1:0]) && (ref_wp[c][AW] != ref_rp[c][AW]);
      duv_full_c[c]  = (duv_wp[c][AW-1:0] == duv_rp[c][AW-1:0]) && (duv_wp[c][AW] != duv_rp[c][AW]);
      // Pop uses registered occupancy, so a fresh push is never compared the same edge
      pop_c[c]       = run_c && !ref_empty_c[c] && !duv_empty_c[c];
      ref_push_c[c]  = run_c && bus.ref_valid[c] && (!ref_full_c[c] || pop_c[c]);
      duv_push_c[c]  = run_c && bus.duv_valid[c] && (!duv_full_c[c] || pop_c[c]);
      ovf_set_c[c]   = run_c && ((bus.ref_valid[c] && ref_full_c[c] && !pop_c[c]) ||
                                 (bus.duv_valid[c] && duv_full_c[c] && !pop_c[c]));
      one_side_c[c]  = ref_empty_c[c] ^ duv_empty_c[c];
      tmo_set_c[c]   = run_c && one_side_c[c] && (skew[c] == SK_W'(MAX_SKEW - 1));
      if (pop_c[c]) begin
        if (ref_mem[c][ref_rp[c][AW-1:0]] == duv_mem[c][duv_rp[c][AW-1:0]]) begin
          match_c[c] = 1'b1;
          n_match_c  = n_match_c + PC_W'(1);
        end else begin
          mis_c[c]   = 1'b1;
          n_mis_c    = n_mis_c + PC_W'(1);
        end
      end
    end
    // Walk downward so the lowest-index mismatch is the one left captured
    for (int c = int'(NUM_CH) - 1; c >= 0; c--) begin
      if (mis_c[c]) begin
        mis_ch_c  = CH_W'(c);
        mis_ref_c = ref_mem[c][ref_rp[c][AW-1:0]];
        mis_duv_c = duv_mem[c][duv_rp[c][AW-1:0]];
      end
    end
    match_sum_c = SUM_W'(match_cnt) + SUM_W'(n_match_c);
    err_sum_c   = SUM_W'(err_cnt) + SUM_W'(n_mis_c);
    match_nx_c  = (match_sum_c > SUM_W'(CNT_MAX)) ? CNT_MAX : match_sum_c[CNT_W-1:0];
    err_nx_c    = (err_sum_c > SUM_W'(CNT_MAX)) ? CNT_MAX : err_sum_c[CNT_W-1:0];
  end

  // FIFO storage; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    for (int c = 0; c < int'(NUM_CH); c++) begin
      if (ref_push_c[c]) ref_mem[c][ref_wp[c][AW-1:0]] <= bus.ref_data[c*DATA_W +: DATA_W];
      if (duv_push_c[c]) duv_mem[c][duv_wp[c][AW-1:0]] <= bus.duv_data[c*DATA_W +: DATA_W];
    end
  end

  // Control FSM, pointers, skew counters, counters and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st            <= S_IDLE;
      match_cnt     <= '0;
      err_cnt       <= '0;
      err_flag      <= 1'b0;
      first_err_ch  <= '0;
      first_err_ref <= '0;
      first_err_duv <= '0;
      ovf_flag      <= '0;
      timeout_flag  <= '0;
      for (int c = 0; c < int'(NUM_CH); c++) begin
        ref_wp[c] <= '0;
        ref_rp[c] <= '0;
        duv_wp[c] <= '0;
        duv_rp[c] <= '0;
        skew[c]   <= '0;
      end
    end else if (clr) begin
      st            <= S_IDLE;
      match_cnt     <= '0;
      err_cnt       <= '0;
      err_flag      <= 1'b0;
      first_err_ch  <= '0;
      first_err_ref <= '0;
      first_err_duv <= '0;
      ovf_flag      <= '0;
      timeout_flag  <= '0;
      for (int c = 0; c < int'(NUM_CH); c++) begin
        ref_wp[c] <= '0;
        ref_rp[c] <= '0;
        duv_wp[c] <= '0;
        duv_rp[c] <= '0;
        skew[c]   <= '0;
      end
    end else begin
      case (st)
        S_IDLE: if (enable) st <= S_RUN;
        S_RUN: begin
          // Halt takes priority over dropping back to idle
          if (stop_on_err && ((|mis_c) || (|tmo_set_c))) st <= S_HALT;
          else if (!enable)                             st <= S_IDLE;
        end
        default: st <= st;
      endcase

      for (int c = 0; c < int'(NUM_CH); c++) begin
        if (ref_push_c[c]) ref_wp[c] <= ref_wp[c] + PW'(1);
        if (duv_push_c[c]) duv_wp[c] <= duv_wp[c] + PW'(1);
        if (pop_c[c]) begin
          ref_rp[c] <= ref_rp[c] + PW'(1);
          duv_rp[c] <= duv_rp[c] + PW'(1);
        end
        if (run_c) begin
          if (!one_side_c[c])                   skew[c] <= '0;
          else if (skew[c] < SK_W'(MAX_SKEW))   skew[c] <= skew[c] + SK_W'(1);
        end
      end

      match_cnt    <= match_nx_c;
      err_cnt      <= err_nx_c;
      ovf_flag     <= ovf_flag | ovf_set_c;
      timeout_flag <= timeout_flag | tmo_set_c;

      if ((|mis_c) && !err_flag) begin
        err_flag      <= 1'b1;
        first_err_ch  <= mis_ch_c;
        first_err_ref <= mis_ref_c;
        first_err_duv <= mis_duv_c;
      end
    end
  end
endmodule

// File: tb/tb_cpu_lockstep_cmp.sv
// Directed bench for cpu_lockstep_cmp (NUM_CH=3, DATA_W=8, DEPTH=4, MAX_SKEW=16).
// A vector table covers compare, skew, first-error capture, enable/idle and
// stop-on-error behaviour; hand sequences cover overflow, timeout and async reset.
module tb_cpu_lockstep_cmp;
  localparam int unsigned NUM_CH   = 3;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned MAX_SKEW = 16;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned NV       = 26;

  logic                 clk;
  logic                 rst_n;
  logic                 enable;
  logic                 stop_on_err;
  logic                 clr;
  logic [1:0]           state;
  logic [CNT_W-1:0]     match_cnt;
  logic [CNT_W-1:0]     err_cnt;
  logic                 err_flag;
  logic [1:0]           first_err_ch;
  logic [DATA_W-1:0]    first_err_ref;
  logic [DATA_W-1:0]    first_err_duv;
  logic [NUM_CH-1:0]    ovf_flag;
  logic [NUM_CH-1:0]    timeout_flag;

  cpu_lockstep_cmp_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

  cpu_lockstep_cmp #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_SKEW(MAX_SKEW), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .stop_on_err(stop_on_err), .clr(clr),
    .bus(bus), .state(state), .match_cnt(match_cnt), .err_cnt(err_cnt),
    .err_flag(err_flag), .first_err_ch(first_err_ch), .first_err_ref(first_err_ref),
    .first_err_duv(first_err_duv), .ovf_flag(ovf_flag), .timeout_flag(timeout_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        stp;
    logic        cl;
    logic [2:0]  rv;
    logic [23:0] rd;
    logic [2:0]  dv;
    logic [23:0] dd;
    logic [1:0]  st;
    logic [15:0] mc;
    logic [15:0] ec;
    logic        ef;
    logic [1:0]  fch;
    logic [7:0]  fr;
    logic [7:0]  fd;
    logic [2:0]  ov;
    logic [2:0]  to;
  } vec_t;

  vec_t vecs [NV];
  int   checks;
  int   errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic stp, input logic cl,
                       input logic [2:0] rv, input logic [23:0] rd,
                       input logic [2:0] dv, input logic [23:0] dd);
    @(negedge clk);
    enable          = en;
    stop_on_err     = stp;
    clr             = cl;
    bus.ref_valid   = rv;
    bus.ref_data    = rd;
    bus.duv_valid   = dv;
    bus.duv_data    = dd;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " state"}, 32'(state), 32'd0);
    chk({tag, " match_cnt"}, 32'(match_cnt), 32'd0);
    chk({tag, " err_cnt"}, 32'(err_cnt), 32'd0);
    chk({tag, " err_flag"}, 32'(err_flag), 32'd0);
    chk({tag, " first_err"}, {14'd0, first_err_ch, first_err_ref, first_err_duv}, 32'd0);
    chk({tag, " ovf_flag"}, 32'(ovf_flag), 32'd0);
    chk({tag, " timeout_flag"}, 32'(timeout_flag), 32'd0);
  endtask

  initial begin
    int tmo_edge;
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    enable      = 1'b0;
    stop_on_err = 1'b0;
    clr         = 1'b0;
    bus.ref_valid = '0;
    bus.ref_data  = '0;
    bus.duv_valid = '0;
    bus.duv_data  = '0;

    //          en    stp   clr   rv      rd            dv      dd            st    mc      ec      ef    fch   fr     fd     ov      to
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 3'b000, 24'h000000, 3'b000, 24'h000000, 2'd1, 16'd0, 16'd0, 1'b0, 2'd0, 8'h00, 8'h00, 3'b000, 3'b000};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 3'b001, 24'h000042, 3'b001, 24'h000042, 2'd1, 16'd0, 16'd0, 1'b0, 2'd0, 8'h00, 8'h00, 3'b000, 3'b000};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 3'b000, 24'h000000, 3'b000, 24'h000000, 2'd1, 16'd1, 16'd0, 1'b0, 2'd0, 8'h00, 8'h00, 3'b000, 3'b000};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 3'b010, 24'h001000, 3'b000, 24'h000000, 2'd1, 16'd1, 16'd0, 1'b0, 2'd0, 8'h00, 8'h00, 3'b000, 3'b000};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 3'b000, 24'h000000, 3'b000, 24'h000000, 2'd1, 16'd1, 16'd0, 1'b0, 2'd0, 8'h00, 8'h00, 3'b000, 3'b000};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 3'b000, 24'h000000, 3'b000, 24'h000000, 2'd1, 16'd1, 16'd0, 1'b0, 2'd0, 8'h00, 8'h00, 3'b000, 3'b000};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 3'b000, 24'h000000, 3'b010, 24'h001000, 2'd1, 16'd1, 16'd0, 1'b0, 2'd0, 8'h00, 8'h00, 3'b000, 3'b000};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 3'b000, 24'h000000, 3'b000, 24'h000000, 2'd1, 16'd2, 16'd0, 1'b0, 2'd0, 8'h00, 8'h00, 3'b000, 3'b000};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 3'b111, 24'h337711, 3'b111, 24'h347712, 2'd1, 16'd2, 16'd0, 1'b0, 2'd0, 8'h00, 8'h00, 3'b000, 3'b000};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 3'b000, 24'h000000, 3'b000, 24'h000000, 2'd1, 16'd3, 16'd2, 1'b1, 2'd0, 8'h11, 8'h12, 3'b000, 3'b000};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 3'b010, 24'h000100, 3'b010, 24'h000200, 2'd1, 16'd3, 16'd2, 1'b1, 2'd0, 8'h11, 8'h12, 3'b000, 3'b000};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 3'b000, 24'h000000, 3'b000, 24'h000000, 2'd1, 16'd3, 16'd3, 1'b1, 2'd0, 8'h11, 8'h12, 3'b000, 3'b000};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 3'b001, 24'h000055, 3'b001, 24'h000055, 2'd1, 16'd3, 16'd3, 1'b1, 2'd0, 8'h11, 8'h12, 3'b000, 3'b000};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 3'b000, 24'h000000, 3'b000, 24'h000000, 2'd0, 16'd4, 16'd3, 1'b1, 2'd0, 8'h11, 8'h12, 3'b000, 3'b000};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 3'b001, 24'h000099, 3'b000, 24'h000000, 2'd0, 16'd4, 16'd3, 1'b1, 2'd0, 8'h11, 8'h12, 3'b000, 3'b000};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 3'b000, 24'h000000, 3'b000, 24'h000000, 2'd1, 16'd4, 16'd3, 1'b1, 2'd0, 8'h11, 8'h12, 3'b000, 3'b000};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 3'b000, 24'h000000, 3'b001, 24'h000099, 2'd1, 16'd4, 16'd3, 1'b1, 2'd0, 8'h11, 8'h12, 3'b000, 3'b000};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 3'b000, 24'h000000, 3'b000, 24'h000000, 2'd1, 16'd4, 16'd3, 1'b1, 2'd0, 8'h11, 8'h12, 3'b000, 3'b000};
    vecs[18] = '{1'b1, 1'b0, 1'b1, 3'b001, 24'h000042, 3'b001, 24'h000042, 2'd0, 16'd0, 16'd0, 1'b0, 2'd0, 8'h00, 8'h00, 3'b000, 3'b000};
    vecs[19] = '{1'b1, 1'b0, 1'b0, 3'b000, 24'h000000, 3'b000, 24'h000000, 2'd1, 16'd0, 16'd0, 1'b0, 2'd0, 8'h00, 8'h00, 3'b000, 3'b000};
    vecs[20] = '{1'b1, 1'b1, 1'b0, 3'b010, 24'h000500, 3'b010, 24'h000600, 2'd1, 16'd0, 16'd0, 1'b0, 2'd0, 8'h00, 8'h00, 3'b000, 3'b000};
    vecs[21] = '{1'b1, 1'b1, 1'b0, 3'b000, 24'h000000, 3'b000, 24'h000000, 2'd2, 16'd0, 16'd1, 1'b1, 2'd1, 8'h05, 8'h06, 3'b000, 3'b000};
    vecs[22] = '{1'b1, 1'b1, 1'b0, 3'b001, 24'h000042, 3'b001, 24'h000042, 2'd2, 16'd0, 16'd1, 1'b1, 2'd1, 8'h05, 8'h06, 3'b000, 3'b000};
    vecs[23] = '{1'b1, 1'b1, 1'b0, 3'b000, 24'h000000, 3'b000, 24'h000000, 2'd2, 16'd0, 16'd1, 1'b1, 2'd1, 8'h05, 8'h06, 3'b000, 3'b000};
    vecs[24] = '{1'b1, 1'b1, 1'b1, 3'b000, 24'h000000, 3'b000, 24'h000000, 2'd0, 16'd0, 16'd0, 1'b0, 2'd0, 8'h00, 8'h00, 3'b000, 3'b000};
    vecs[25] = '{1'b1, 1'b0, 1'b0, 3'b000, 24'h000000, 3'b000, 24'h000000, 2'd1, 16'd0, 16'd0, 1'b0, 2'd0, 8'h00, 8'h00, 3'b000, 3'b000};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < int'(NV); i++) begin
      drive(vecs[i].en, vecs[i].stp, vecs[i].cl, vecs[i].rv, vecs[i].rd, vecs[i].dv, vecs[i].dd);
      chk($sformatf("v%0d state", i), 32'(state), 32'(vecs[i].st));
      chk($sformatf("v%0d match_cnt", i), 32'(match_cnt), 32'(vecs[i].mc));
      chk($sformatf("v%0d err_cnt", i), 32'(err_cnt), 32'(vecs[i].ec));
      chk($sformatf("v%0d err_flag", i), 32'(err_flag), 32'(vecs[i].ef));
      chk($sformatf("v%0d first_err_ch", i), 32'(first_err_ch), 32'(vecs[i].fch));
      chk($sformatf("v%0d first_err_ref", i), 32'(first_err_ref), 32'(vecs[i].fr));
      chk($sformatf("v%0d first_err_duv", i), 32'(first_err_duv), 32'(vecs[i].fd));
      chk($sformatf("v%0d ovf_flag", i), 32'(ovf_flag), 32'(vecs[i].ov));
      chk($sformatf("v%0d timeout_flag", i), 32'(timeout_flag), 32'(vecs[i].to));
    end

    // Overflow on a 4-deep FIFO, then skew timeout counted from the first push edge
    tmo_edge = -1;
    for (int e = 0; e < 40; e++) begin
      if (e < 5) drive(1'b1, 1'b0, 1'b0, 3'b001, 24'(8'hA0 + 8'(e)), 3'b000, 24'h0);
      else       drive(1'b1, 1'b0, 1'b0, 3'b000, 24'h0, 3'b000, 24'h0);
      if (e == 3) chk("ovf before 5th push", 32'(ovf_flag), 32'b000);
      if (e == 4) chk("ovf after 5th push", 32'(ovf_flag), 32'b001);
      if (timeout_flag[0]) begin
        tmo_edge = e;
        break;
      end
    end
    chk("timeout edge", 32'(tmo_edge), 32'd16);
    chk("timeout_flag", 32'(timeout_flag), 32'b001);
    chk("state after timeout", 32'(state), 32'd1);

    // Drain: only the four accepted entries compare
    for (int e = 0; e < 4; e++) drive(1'b1, 1'b0, 1'b0, 3'b000, 24'h0, 3'b001, 24'(8'hA0 + 8'(e)));
    repeat (2) drive(1'b1, 1'b0, 1'b0, 3'b000, 24'h0, 3'b000, 24'h0);
    chk("drain match_cnt", 32'(match_cnt), 32'd4);
    chk("drain err_cnt", 32'(err_cnt), 32'd0);
    chk("drain ovf sticky", 32'(ovf_flag), 32'b001);
    chk("drain timeout sticky", 32'(timeout_flag), 32'b001);

    // Async reset mid-cycle with a stale one-sided entry queued
    drive(1'b1, 1'b0, 1'b0, 3'b100, 24'h7E0000, 3'b000, 24'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b1;
    bus.ref_valid = '0;
    bus.duv_valid = '0;
    @(posedge clk);
    #1;
    chk("post-reset state", 32'(state), 32'd1);
    drive(1'b1, 1'b0, 1'b0, 3'b100, 24'h110000, 3'b100, 24'h110000);
    drive(1'b1, 1'b0, 1'b0, 3'b000, 24'h0, 3'b000, 24'h0);
    chk("post-reset match_cnt", 32'(match_cnt), 32'd1);
    chk("post-reset err_cnt", 32'(err_cnt), 32'd0);
    chk("post-reset err_flag", 32'(err_flag), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
